// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WAIT_CNT_W = 4;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Reset-clearable word storage: one synchronous write port, one registered read port.
// With DMEM_PARITY_EN defined, a parity bit column is stored and read alongside the data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE = 256,
  parameter int IDX_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
`ifdef DMEM_PARITY_EN
  input  logic             wpar,
  output logic             rd_par,
`endif
  output logic [7:0]       rd_data
);
  logic [7:0] mem_q [MEM_SIZE];
  logic [7:0] mem_d [MEM_SIZE];
  logic [7:0] rd_data_q, rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[idx] = wdata;
    rd_data_d = rd_data_q;
    if (rd_clr)     rd_data_d = '0;
    else if (rd_en) rd_data_d = mem_q[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

`ifdef DMEM_PARITY_EN
  logic par_q [MEM_SIZE];
  logic par_d [MEM_SIZE];
  logic rd_par_q, rd_par_d;

  always_comb begin
    par_d = par_q;
    if (wr_en) par_d[idx] = wpar;
    rd_par_d = rd_par_q;
    if (rd_clr)     rd_par_d = 1'b0;
    else if (rd_en) rd_par_d = par_q[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_q    <= '{default: 1'b0};
      rd_par_q <= 1'b0;
    end else begin
      par_q    <= par_d;
      rd_par_q <= rd_par_d;
    end
  end

  assign rd_par = rd_par_q;
`endif
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, WAIT_STATES latency.
// Define DMEM_PARITY_EN to add per-word parity checking and the err_inject input.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDRESS_LINE = 8,
  parameter int MEM_SIZE     = 256,
  parameter int WAIT_STATES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS_LINE-1:0] req_addr,
  input  logic [7:0]              req_wdata,
`ifdef DMEM_PARITY_EN
  input  logic                    err_inject,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);
  // state | meaning
  // IDLE  | ready to accept a request
  // WAIT  | counting down access latency
  // RESP  | response held until rsp_ready
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDRESS_LINE-1:0] addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    err_q, err_d;

  logic                    acc_fire, acc_write, acc_oor, rsp_hs;
  logic [ADDRESS_LINE-1:0] acc_addr;
  logic [7:0]              acc_wdata;
  logic                    arr_wr, arr_rd, arr_clr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    acc_fire  = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    rsp_hs    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // Zero wait states: the accept edge is also the access edge.
          if (WAIT_STATES == 0) begin
            acc_fire  = 1'b1;
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            state_d   = RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          acc_fire = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    acc_oor = 32'(acc_addr) >= 32'(MEM_SIZE);
    if (acc_fire)    err_d = acc_oor;
    else if (rsp_hs) err_d = 1'b0;
  end

  assign arr_wr  = acc_fire & acc_write & ~acc_oor;
  assign arr_rd  = acc_fire & ~acc_write & ~acc_oor;
  assign arr_clr = (acc_fire & (acc_write | acc_oor)) | rsp_hs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_PARITY_EN
  logic inj_q, inj_d, acc_inj, arr_wpar, arr_rd_par;

  always_comb begin
    inj_d = inj_q;
    if (state_q == IDLE && req_valid) inj_d = err_inject;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) inj_q <= 1'b0;
    else       inj_q <= inj_d;
  end

  assign acc_inj  = (WAIT_STATES == 0) ? err_inject : inj_q;
  assign arr_wpar = parity8(acc_wdata) ^ acc_inj;
  // Cleared read register holds 0 data with 0 parity, so no false error outside a load.
  assign rsp_err  = err_q | (arr_rd_par ^ parity8(rsp_rdata));
`else
  assign rsp_err  = err_q;
`endif

  dmem_array #(
    .MEM_SIZE (MEM_SIZE),
    .IDX_W    (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (arr_wr),
    .rd_en   (arr_rd),
    .rd_clr  (arr_clr),
    .idx     (acc_addr[IDX_W-1:0]),
    .wdata   (acc_wdata),
`ifdef DMEM_PARITY_EN
    .wpar    (arr_wpar),
    .rd_par  (arr_rd_par),
`endif
    .rd_data (rsp_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with different latency/size settings.
module tb_dmem_responder;
  localparam int WS [3] = '{2, 0, 3};
  localparam int MS [3] = '{256, 256, 128};

  logic             clock, reset;
  logic [2:0]       req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0][7:0]  req_addr, req_wdata, rsp_rdata;
`ifdef DMEM_PARITY_EN
  logic [2:0]       err_inject;
`endif

  int checks, failures;

  // Reference: plain per-instance memory image plus "parity was corrupted" flags.
  logic [7:0] mem_m [3][256];
  bit         bad_m [3][256];

  typedef struct {
    int         k;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    bit         inj;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;
  vec_t vecs [$];

  dmem_responder #(.ADDRESS_LINE(8), .MEM_SIZE(256), .WAIT_STATES(2)) u_dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_PARITY_EN
    .err_inject(err_inject[0]),
`endif
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]));

  dmem_responder #(.ADDRESS_LINE(8), .MEM_SIZE(256), .WAIT_STATES(0)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_PARITY_EN
    .err_inject(err_inject[1]),
`endif
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]));

  dmem_responder #(.ADDRESS_LINE(8), .MEM_SIZE(128), .WAIT_STATES(3)) u_dut2 (
    .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
`ifdef DMEM_PARITY_EN
    .err_inject(err_inject[2]),
`endif
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 256; i++) begin
        mem_m[k][i] = 8'h00;
        bad_m[k][i] = 1'b0;
      end
  endfunction

  function automatic void model_access(input int k, input bit wr, input logic [7:0] a,
                                       input logic [7:0] d, input bit inj,
                                       output logic [7:0] rd, output bit er);
    if (int'(a) >= MS[k]) begin
      rd = 8'h00; er = 1'b1;
    end else if (wr) begin
      rd = 8'h00; er = 1'b0;
      mem_m[k][a] = d;
      bad_m[k][a] = inj;
    end else begin
      rd = mem_m[k][a]; er = bad_m[k][a];
    end
  endfunction

  function automatic logic [31:0] idle_vec(input int k);
    return 32'({rsp_valid[k], rsp_rdata[k], rsp_err[k], busy[k], req_ready[k]});
  endfunction

  task automatic drive_req(input int k, input bit wr, input logic [7:0] a,
                           input logic [7:0] d, input bit inj);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
`ifdef DMEM_PARITY_EN
    err_inject[k] = inj;
`else
    if (inj) $display("note: err_inject requested without parity build");
`endif
  endtask

  task automatic access(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input bit inj, input int hold, input string tag,
                        output logic [7:0] rd, output logic er);
    bit seen;
    int lat;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (req_ready[k]) seen = 1'b1;
    end
    chk({tag, "_ready"}, 32'(seen), 32'd1);
    drive_req(k, wr, a, d, inj);
    rsp_ready[k] = (hold == 0);
    @(posedge clock); #1;
    req_valid[k] = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      lat++;
      if (rsp_valid[k]) seen = 1'b1;
    end
    chk({tag, "_lat"}, seen ? 32'(lat) : 32'd0, 32'(WS[k] + 1));
    rd = rsp_rdata[k];
    er = rsp_err[k];
    chk({tag, "_busy"}, 32'({req_ready[k], busy[k]}), 32'b01);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk({tag, "_hold"}, 32'({rsp_valid[k], rsp_rdata[k], rsp_err[k]}), 32'({1'b1, rd, er}));
    end
    rsp_ready[k] = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_done"}, idle_vec(k), 32'd1);
  endtask

  task automatic wait_idle(input int k, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (!busy[k]) seen = 1'b1;
    end
    chk({tag, "_idle"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [7:0] rd, m_rd;
    logic       er;
    bit         m_er;
    int         rise [$];
    bit         prev;
    int         k, hold;
    bit         wr, inj;
    logic [7:0] a, d, base;

    checks = 0; failures = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
`ifdef DMEM_PARITY_EN
    err_inject = '0;
`endif
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_state%0d", i), idle_vec(i), 32'd1);
    @(negedge clock);
    reset = 1'b0;

    vecs.push_back('{0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b1, 8'hFF, 8'h3C, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h3C, 1'b0});
    vecs.push_back('{1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1, 1'b1, 8'h05, 8'hC3, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hC3, 1'b0});
    vecs.push_back('{2, 1'b1, 8'h10, 8'h11, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{2, 1'b1, 8'h90, 8'hEE, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{2, 1'b0, 8'h90, 8'h00, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{2, 1'b0, 8'h10, 8'h00, 1'b0, 8'h11, 1'b0});
    vecs.push_back('{2, 1'b1, 8'h7F, 8'h80, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{2, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{2, 1'b0, 8'h80, 8'h00, 1'b0, 8'h00, 1'b1});
`ifdef DMEM_PARITY_EN
    vecs.push_back('{0, 1'b1, 8'h01, 8'h0F, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h0F, 1'b1});
    vecs.push_back('{0, 1'b1, 8'h03, 8'h0F, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h03, 8'h00, 1'b0, 8'h0F, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1, 1'b1, 8'h40, 8'h81, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h81, 1'b1});
`endif

    foreach (vecs[i]) begin
      access(vecs[i].k, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].inj, 0,
             $sformatf("vec%0d", i), rd, er);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      model_access(vecs[i].k, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].inj, m_rd, m_er);
    end

    // Throughput: request held valid with rsp_ready high, accepts spaced WAIT_STATES+2 apart.
    @(negedge clock);
    rsp_ready[0] = 1'b1;
    drive_req(0, 1'b0, 8'h10, 8'h00, 1'b0);
    prev = busy[0];
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      if (busy[0] && !prev) rise.push_back(i);
      prev = busy[0];
    end
    req_valid[0] = 1'b0;
    chk("throughput", (rise.size() >= 2) ? 32'(rise[1] - rise[0]) : 32'hFFFF, 32'(WS[0] + 2));
    wait_idle(0, "tput");

    // Response back-pressure: 5 cycles of rsp_ready low with a new request pending.
    access(0, 1'b1, 8'h3C, 8'h77, 1'b0, 0, "bp_setup", rd, er);
    model_access(0, 1'b1, 8'h3C, 8'h77, 1'b0, m_rd, m_er);
    @(negedge clock);
    rsp_ready[0] = 1'b0;
    drive_req(0, 1'b0, 8'h3C, 8'h00, 1'b0);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 20 && !prev; i++) begin
      @(negedge clock);
      if (rsp_valid[0]) prev = 1'b1;
    end
    chk("bp_resp", 32'(prev), 32'd1);
    drive_req(0, 1'b1, 8'h3C, 8'h11, 1'b0);
    for (int h = 0; h < 5; h++) begin
      if (h > 0) @(negedge clock);
      chk($sformatf("bp_stable%0d", h),
          32'({rsp_valid[0], rsp_rdata[0], rsp_err[0], busy[0], req_ready[0]}),
          32'({1'b1, 8'h77, 1'b0, 1'b1, 1'b0}));
    end
    rsp_ready[0] = 1'b1;
    @(posedge clock); #1;
    chk("bp_after_hs", idle_vec(0), 32'd1);
    @(posedge clock); #1;
    chk("bp_accept_next", 32'(busy[0]), 32'd1);
    req_valid[0] = 1'b0;
    wait_idle(0, "bp");
    model_access(0, 1'b1, 8'h3C, 8'h11, 1'b0, m_rd, m_er);
    access(0, 1'b0, 8'h3C, 8'h00, 1'b0, 0, "bp_check", rd, er);
    chk("bp_store_taken", 32'(rd), 32'h11);

    // Reset in the middle of a store's wait period: store is dropped, memory cleared.
    access(0, 1'b1, 8'h20, 8'h5A, 1'b0, 0, "rst_setup", rd, er);
    access(0, 1'b0, 8'h20, 8'h00, 1'b0, 0, "rst_pre", rd, er);
    chk("rst_pre_rdata", 32'(rd), 32'h5A);
    @(negedge clock);
    drive_req(0, 1'b1, 8'h20, 8'hFF, 1'b0);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    @(negedge clock);
    chk("rst_in_wait", 32'({busy[0], rsp_valid[0]}), 32'b10);
    reset = 1'b1;
    #1;
    chk("rst_async", idle_vec(0), 32'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    access(0, 1'b0, 8'h20, 8'h00, 1'b0, 0, "rst_post", rd, er);
    chk("rst_post_rdata", 32'({rd, er}), 32'h0);

    // Randomized traffic against the reference image.
    for (int it = 0; it < 90; it++) begin
      k    = it % 3;
      wr   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: base = 8'h00;
        1: base = 8'h10;
        2: base = 8'h78;
        3: base = 8'h88;
        default: base = 8'hF8;
      endcase
      a    = base + 8'($urandom_range(0, 7));
      d    = 8'($urandom_range(0, 255));
`ifdef DMEM_PARITY_EN
      inj  = ($urandom_range(0, 3) == 0);
`else
      inj  = 1'b0;
`endif
      hold = $urandom_range(0, 2);
      access(k, wr, a, d, inj, hold, $sformatf("rnd%0d", it), rd, er);
      model_access(k, wr, a, d, inj, m_rd, m_er);
      chk($sformatf("rnd%0d_rsp k=%0d wr=%0d a=%0h", it, k, wr, a),
          32'({rd, er}), 32'({m_rd, m_er}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM stage's data-memory request interface of the 8-bit RISC-V pipeline.
- Accepts one load or store at a time over a valid/ready request channel.
- Models WAIT_STATES cycles of access latency, then returns read data or a store acknowledgement over a valid/ready response channel.
- Drives busy so the hazard unit can stall the pipeline while an access is outstanding.

Parameters:
- ADDRESS_LINE, 8, request address width in bits.
- MEM_SIZE, 256, number of 8-bit words; must be at most 2**ADDRESS_LINE.
- WAIT_STATES, 2, extra cycles between request accept and response; legal range 0..15.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDRESS_LINE  word address (the ALU result).
- req_wdata  input  8  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  8  load data; 0 for stores and errors.
- rsp_err  output  1  access error flag, qualified by rsp_valid.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high, may assert in any state):
  - State goes to IDLE and the wait counter clears.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1.
  - Every memory word clears to 0.
  - An in-flight access is dropped; a pending store is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture write, addr and wdata at the rising edge (this is the accept edge, cycle T).
  - Next state is WAIT with the counter loaded to WAIT_STATES-1, or RESP directly if WAIT_STATES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 0, the memory access executes on that edge and the state moves to RESP.
- Access rules:
  - Store writes wdata to mem[addr].
  - Load registers mem[addr] into rsp_rdata.
  - Out of range means addr >= MEM_SIZE: rsp_err=1, rsp_rdata=0, and a store is discarded.
  - The memory image changes only at the access edge.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable until the handshake.
  - On rsp_ready the state returns to IDLE; rsp_valid, rsp_rdata and rsp_err clear to 0 on that edge.
- Latency: rsp_valid first asserts in cycle T+1+WAIT_STATES.
- Throughput: with rsp_ready tied high, a new request can be accepted once every WAIT_STATES+2 cycles.
- Requests while busy: req_valid asserted outside IDLE is ignored, because req_ready=0. The requester holds the request.
- Response ordering: strictly one outstanding access, so responses return in order by construction.
- Back-to-back access: a load issued after a store to the same address returns the stored value.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- When defined:
  - Each word carries one even-parity bit, computed on store and cleared by reset.
  - Extra input err_inject (1 bit), sampled with the request; a store accepted with err_inject=1 stores an inverted parity bit.
  - On a load, a parity mismatch sets rsp_err=1 but rsp_rdata still returns the stored byte.
- When undefined:
  - No parity storage and no err_inject port.
  - rsp_err reflects only out-of-range accesses.

Decomposition:
- Package dmem_pkg holds:
  - the state enum IDLE/WAIT/RESP;
  - WAIT_CNT_W = 4;
  - a parity helper function.
- Sub-module dmem_array:
  - reset-clearable storage of MEM_SIZE words;
  - one synchronous write port and one registered read port;
  - optional parity bit column.
  - The responder owns the FSM, counter, range check and handshakes.

Test Plan:
- Reset then store 0xA5 to addr 0x10 with WAIT_STATES=2, rsp_ready=1 -> rsp_valid at T+3 with rsp_rdata=0, rsp_err=0; a following load of 0x10 returns 0xA5.
- WAIT_STATES=0, load of addr 0x05 after reset -> rsp_valid at T+1, rsp_rdata=0x00, req_ready low exactly one cycle.
- rsp_ready held low 5 cycles during a load of 0x3C (mem=0x77) -> rsp_valid and rsp_rdata=0x77 stable all 5 cycles, busy=1, new req_valid ignored; it is accepted only the cycle after the handshake.
- MEM_SIZE=128, store to 0x90 followed by a load of 0x90 -> both responses have rsp_err=1 and rsp_rdata=0; mem[0x10] (aliased low bits) remains unchanged.
- Store 0x5A to 0x20, assert reset during WAIT of a second store of 0xFF to 0x20 -> outputs return to reset values immediately; a later load of 0x20 returns 0x00.
- With DMEM_PARITY_EN: store 0x0F to 0x01 with err_inject=1, then load 0x01 -> rsp_rdata=0x0F, rsp_err=1; an uninjected address returns rsp_err=0.
